contador_updown_param: RTL
==========================

CONTADOR_UPDOWN_PARAM -- requirements
Module: contador_updown_param

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits (2..16).
REQ-002 Parameter STEP, default 1: increment/decrement magnitude (1..2^WIDTH-1).
REQ-003 Parameter MIN_VAL, default 0: lower count limit; MIN_VAL < MAX_VAL.
REQ-004 Parameter MAX_VAL, default 2^WIDTH-1: upper count limit.
REQ-005 Parameter WRAP, default 0: 0 = saturate at limits, 1 = wrap between limits.
REQ-006 Parameter HOLD_CYCLES, default 0: hold time before auto-repeat starts; 0 = auto-repeat disabled.
REQ-007 Parameter REPEAT_CYCLES, default 1: auto-repeat period in cycles (>=1).
REQ-008 clock  input  1  single system clock, all flops on rising edge.
REQ-009 areset_n  input  1  reset, asynchronous, active-low.
REQ-010 Key2  input  1  "up" pushbutton, active-low, asynchronous to clock.
REQ-011 Key1  input  1  "down" pushbutton, active-low, asynchronous to clock.
REQ-012 count  output  WIDTH  registered counter value.
REQ-013 at_max  output  1  registered flag, count == MAX_VAL.
REQ-014 at_min  output  1  registered flag, count == MIN_VAL.
REQ-015 step_pulse  output  1  Moore output, high exactly in cycles where count is enabled to change.

Function
REQ-016 Key2/Key1 SHALL pass through 2-flop synchronisers (reset value 1 = released); FSM uses synchronised values k2/k1 only.
REQ-017 Decode: up = k2==0 && k1==1; down = k1==0 && k2==0 false... i.e. down = k1==0 && k2==1; released = k2==1 && k1==1; both = k2==0 && k1==0.
REQ-018 FSM states: IDLE, SUBIR, BAJAR, HOLD, REPOSO; Moore outputs only.
REQ-019 IDLE: up && count!=MAX_VAL (or WRAP=1) -> SUBIR; down && count!=MIN_VAL (or WRAP=1) -> BAJAR; otherwise stay IDLE (press at saturated limit produces no step).
REQ-020 SUBIR/BAJAR last exactly one cycle; step_pulse=1, direction up/down; then -> HOLD if HOLD_CYCLES>0, else -> REPOSO.
REQ-021 HOLD: cycle counter runs while the same key stays held; released -> IDLE; any other key combination -> REPOSO; counter reaches HOLD_CYCLES (first repeat) or REPEAT_CYCLES (later repeats) -> SUBIR/BAJAR per held key, subject to REQ-019 limit check; at saturated limit remain in HOLD, no step.
REQ-022 REPOSO: stay until released, then -> IDLE.
REQ-023 Count update at the clock edge ending a SUBIR/BAJAR cycle: latency from synchronised key edge to count change = 2 cycles (IDLE->SUBIR, SUBIR->update).
REQ-024 Saturate (WRAP=0): up result = min(count+STEP, MAX_VAL); down result = max(count-STEP, MIN_VAL); arithmetic in WIDTH+1 bits, no overflow aliasing.
REQ-025 Wrap (WRAP=1): up with count+STEP > MAX_VAL -> MIN_VAL; down with count-STEP < MIN_VAL (incl. borrow) -> MAX_VAL; otherwise normal step.
REQ-026 at_max/at_min SHALL be updated in the same edge as count and always consistent with it.
REQ-027 Unused state encodings SHALL return to IDLE on next edge.

Reset
REQ-028 areset_n low SHALL immediately force count=MIN_VAL, at_min=1, at_max=0 (1 if MIN_VAL==MAX_VAL not allowed), step_pulse=0, FSM=IDLE, hold counter=0, synchronisers=1.
REQ-029 Reset asserted mid-HOLD or mid-SUBIR SHALL discard the pending step; after deassertion a still-held key is treated as a new press once synchronised.

Verification
REQ-030 Defaults; Key2 low 50 cycles then release -> count 0->1 once, step_pulse high exactly 1 cycle, FSM back to IDLE.
REQ-031 Defaults; count=0, Key1 low -> count stays 0, at_min=1, step_pulse never high; count=15, Key2 low -> stays 15, at_max=1.
REQ-032 WRAP=1, STEP=3, MAX_VAL=9: count 9, up press -> 0; count 1, down press -> 9.
REQ-033 HOLD_CYCLES=4, REPEAT_CYCLES=2, saturate: Key2 held 20 cycles from 0 -> first step, then steps spaced 2 cycles after 4-cycle hold, count saturates at 15 if reached, no wrap.
REQ-034 Both keys low in IDLE -> no change; up held then Key1 also pressed -> REPOSO, no further steps until both released.
REQ-035 Reset pulse while Key2 held in HOLD -> count=MIN_VAL immediately, one new step 2 synchroniser + 2 cycles after deassertion.

Source files
------------

// File: rtl/contador_updown_param.sv
// -----------------------------------------------------------------------------
// contador_updown_param
//
// Up/down counter driven by two active-low pushbuttons, with saturating or
// wrapping limits and an optional press-and-hold auto-repeat.
//
// Each button passes through a 2-flop synchroniser. A Moore FSM then turns a
// press into one-cycle step requests (SUBIR = up, BAJAR = down). If
// HOLD_CYCLES > 0, keeping the same key held also produces repeated steps.
//
// Ports
//   clock       system clock; every flop uses its rising edge
//   areset_n    asynchronous active-low reset
//   Key2        "up" pushbutton, active-low, asynchronous to clock
//   Key1        "down" pushbutton, active-low, asynchronous to clock
//   count       registered counter value, range MIN_VAL..MAX_VAL
//   at_max      registered flag, count == MAX_VAL
//   at_min      registered flag, count == MIN_VAL
//   step_pulse  high exactly in the cycles where count is about to change
// -----------------------------------------------------------------------------
module contador_updown_param #(
  parameter int WIDTH         = 4,
  parameter int STEP          = 1,
  parameter int MIN_VAL       = 0,
  parameter int MAX_VAL       = (1 << WIDTH) - 1,
  parameter int WRAP          = 0,
  parameter int HOLD_CYCLES   = 0,
  parameter int REPEAT_CYCLES = 1
) (
  input  logic             clock,
  input  logic             areset_n,
  input  logic             Key2,
  input  logic             Key1,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_min,
  output logic             step_pulse
);

  // The hold counter must be able to reach the larger of the two wait times.
  localparam int HOLD_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HCW      = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);

  // Step arithmetic uses one extra bit, so neither carry nor borrow can alias
  // onto a legal value.
  localparam logic [WIDTH:0]   STEP_X = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0]   MAX_X  = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0]   MIN_X  = (WIDTH+1)'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] MIN_W  = WIDTH'(MIN_VAL);
  localparam logic [HCW:0]     HOLD_T = (HCW+1)'(HOLD_CYCLES);
  localparam logic [HCW:0]     REP_T  = (HCW+1)'(REPEAT_CYCLES);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SUBIR  = 3'd1,
    BAJAR  = 3'd2,
    HOLD   = 3'd3,
    REPOSO = 3'd4
  } state_t;

  state_t           state;
  logic             key2_meta, key1_meta, k2, k1;
  logic             up, down, released;
  logic             can_up, can_down;
  logic [WIDTH:0]   up_sum, dn_diff;
  logic             dn_under;
  logic [WIDTH-1:0] up_res, dn_res;
  logic [HCW-1:0]   hold_cnt;
  logic [HCW:0]     hold_inc, hold_target;
  logic             dir_up;     // direction of the step that began this press
  logic             first_rep;  // the next repeat is the first one (uses HOLD_CYCLES)

  // Two-flop synchronisers. They reset to 1, which means "released".
  always_ff @(posedge clock or negedge areset_n) begin
    if (!areset_n) begin
      key2_meta <= 1'b1;
      key1_meta <= 1'b1;
      k2        <= 1'b1;
      k1        <= 1'b1;
    end else begin
      key2_meta <= Key2;
      key1_meta <= Key1;
      k2        <= key2_meta;
      k1        <= key1_meta;
    end
  end

  assign up       = !k2 &&  k1;
  assign down     =  k2 && !k1;
  assign released =  k2 &&  k1;

  // In wrap mode a step is always allowed. In saturate mode a step is refused
  // when count already sits at the limit in that direction.
  assign can_up   = (WRAP != 0) || (count != MAX_W);
  assign can_down = (WRAP != 0) || (count != MIN_W);

  assign up_sum   = {1'b0, count} + STEP_X;
  assign dn_diff  = {1'b0, count} - STEP_X;
  // The first term catches a borrow out of the real width. In that case
  // dn_diff has wrapped to a large value and must not be compared directly.
  assign dn_under = ({1'b0, count} < STEP_X) || (dn_diff < MIN_X);

  always_comb begin
    up_res = up_sum[WIDTH-1:0];
    dn_res = dn_diff[WIDTH-1:0];
    if (up_sum > MAX_X) begin
      up_res = (WRAP != 0) ? MIN_W : MAX_W;
    end
    if (dn_under) begin
      dn_res = (WRAP != 0) ? MAX_W : MIN_W;
    end
  end

  assign hold_inc    = {1'b0, hold_cnt} + (HCW+1)'(1);
  assign hold_target = first_rep ? HOLD_T : REP_T;

  // Control FSM. The count, the limit flags and step_pulse are all registered
  // in this one block.
  // step_pulse is set on the same edge that enters SUBIR/BAJAR, so it is high
  // exactly while the FSM is in a step state.
  // A HOLD phase lasts N cycles (N = HOLD_CYCLES for the first repeat,
  // REPEAT_CYCLES for later ones) and is followed by a step cycle.
  always_ff @(posedge clock or negedge areset_n) begin
    if (!areset_n) begin
      state      <= IDLE;
      count      <= MIN_W;
      at_max     <= 1'b0;
      at_min     <= 1'b1;
      step_pulse <= 1'b0;
      hold_cnt   <= '0;
      dir_up     <= 1'b1;
      first_rep  <= 1'b1;
    end else begin
      step_pulse <= 1'b0;
      case (state)
        IDLE: begin
          hold_cnt <= '0;
          if (up && can_up) begin
            state      <= SUBIR;
            dir_up     <= 1'b1;
            first_rep  <= 1'b1;
            step_pulse <= 1'b1;
          end else if (down && can_down) begin
            state      <= BAJAR;
            dir_up     <= 1'b0;
            first_rep  <= 1'b1;
            step_pulse <= 1'b1;
          end
        end

        SUBIR: begin
          count    <= up_res;
          at_max   <= (up_res == MAX_W);
          at_min   <= (up_res == MIN_W);
          hold_cnt <= '0;
          state    <= (HOLD_CYCLES > 0) ? HOLD : REPOSO;
        end

        BAJAR: begin
          count    <= dn_res;
          at_max   <= (dn_res == MAX_W);
          at_min   <= (dn_res == MIN_W);
          hold_cnt <= '0;
          state    <= (HOLD_CYCLES > 0) ? HOLD : REPOSO;
        end

        HOLD: begin
          if (released) begin
            state    <= IDLE;
            hold_cnt <= '0;
          end else if (dir_up ? up : down) begin
            if (hold_inc >= hold_target) begin
              // When the limit blocks the step, the counter simply stays at
              // its terminal value. The FSM then waits in HOLD with no step.
              if (dir_up && can_up) begin
                state      <= SUBIR;
                step_pulse <= 1'b1;
                hold_cnt   <= '0;
                first_rep  <= 1'b0;
              end else if (!dir_up && can_down) begin
                state      <= BAJAR;
                step_pulse <= 1'b1;
                hold_cnt   <= '0;
                first_rep  <= 1'b0;
              end
            end else begin
              hold_cnt <= hold_inc[HCW-1:0];
            end
          end else begin
            // The other key was added, or the keys swapped: block until both are released.
            state    <= REPOSO;
            hold_cnt <= '0;
          end
        end

        REPOSO: begin
          hold_cnt <= '0;
          if (released) begin
            state <= IDLE;
          end
        end

        default: begin
          state    <= IDLE;
          hold_cnt <= '0;
        end
      endcase
    end
  end

endmodule
